output_feature_writer: RTL

//   Write-back end of the convolution datapath: accepts 128-bit output-pixel beats
//   (16 och x 8b) from the MAC/quantize stage and stores them into the OFM BRAM as
//   32-bit words. Layout is NHWC-linear, so the next layer's input line loader reads
//   it unchanged. Buffers beats in a small FIFO so the 4-words-per-beat drain rate

---
 rtl/output_feature_writer_pkg.sv | 46 ++++
 rtl/output_feature_writer_ofm_beat_fifo.sv | 52 +++++
 rtl/output_feature_writer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/output_feature_writer_pkg.sv
// Shared constants, FSM state type and configuration helpers for the OFM write-back block.
package output_feature_writer_pkg;

   localparam int unsigned OFM_BITS   = 8;
   localparam int unsigned OFM_NUM    = 16;
   localparam int unsigned DIN_W      = OFM_BITS * OFM_NUM;
   localparam int unsigned WORD_NUM   = 4;
   localparam int unsigned W_DATA_W   = OFM_BITS * WORD_NUM;
   localparam int unsigned BEAT_WORDS = DIN_W / W_DATA_W;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W      = 17;
   localparam int unsigned CFG_W      = 9;

   localparam logic [FIFO_AW:0] FIFO_CNT_MAX = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // A beat viewed as an array of BRAM words; word k sits at bits [k*32 +: 32].
   typedef logic [BEAT_WORDS-1:0][W_DATA_W-1:0] beat_words_t;

   // Words per beat: narrow layers (och < 16) only fill the low och/4 words.
   function automatic logic [2:0] calc_wpb(input logic [CFG_W-1:0] c);
      if (c < CFG_W'(16)) return c[4:2];
      else                return 3'd4;
   endfunction

   // Beats in a frame: one beat per pixel per group of 16 channels (at least one group).
   function automatic logic [CNT_W-1:0] calc_beats(input logic [CFG_W-1:0] w,
                                                   input logic [CFG_W-1:0] c);
      logic [4:0] m;
      m = (c[8:4] == 5'd0) ? 5'd1 : c[8:4];
      return CNT_W'((23'(w) * 23'(w)) * 23'(m));
   endfunction

   function automatic logic [CNT_W-1:0] calc_words(input logic [CFG_W-1:0] w,
                                                   input logic [CFG_W-1:0] c);
      return CNT_W'(calc_beats(w, c) * CNT_W'(calc_wpb(c)));
   endfunction

endpackage

// File: rtl/output_feature_writer_ofm_beat_fifo.sv
// Small synchronous beat FIFO decoupling the producer from the 1-word/cycle BRAM drain.
module ofm_beat_fifo
   import output_feature_writer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [DIN_W-1:0]   i_din,
   output logic [DIN_W-1:0]   o_dout,
   output logic               o_full,
   output logic               o_empty,
   output logic [FIFO_AW:0]   o_count
);

   logic [DIN_W-1:0]   r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == FIFO_CNT_MAX);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/output_feature_writer.sv
// OFM write-back: buffers 128-bit output beats and serialises them into 32-bit BRAM words
// at consecutive NHWC-linear addresses, pulsing ap_done after the final word.
module output_feature_writer
   import output_feature_writer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                ap_start,
   input  logic [CFG_W-1:0]    ofm_w,
   input  logic [CFG_W-1:0]    och,
   input  logic [DIN_W-1:0]    din,
   input  logic                i_vld,
   output logic                i_rdy,
   output logic [ADDR_W-1:0]   w_addr,
   output logic [W_DATA_W-1:0] w_data,
   output logic                w_en,
   output logic                busy,
   output logic                ap_done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_wpb;
   logic [CNT_W-1:0] r_beats_total;
   logic [CNT_W-1:0] r_words_total;
   logic [CNT_W-1:0] r_beats_acc;
   logic [CNT_W-1:0] r_words_cnt;
   logic [1:0]       r_k;

   logic             w_start;
   logic             w_push;
   logic             w_pop;
   logic             w_issue;
   logic             w_last_k;
   logic [DIN_W-1:0] w_fifo_head;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [FIFO_AW:0] w_fifo_count;
   beat_words_t      w_head_words;

   assign w_start      = (r_state == ST_IDLE) && ap_start;
   assign w_push       = i_vld && i_rdy && !w_fifo_full;
   assign w_head_words = w_fifo_head;
   assign w_last_k     = ({1'b0, r_k} == (r_wpb - 3'd1));
   assign w_issue      = (r_state == ST_RUN) && !w_fifo_empty && (r_words_cnt != r_words_total);
   assign w_pop        = w_issue && w_last_k;

   ofm_beat_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (din),
      .o_dout  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and handshake/status outputs; all derived from registered state only.
   always_comb begin
      w_state_nxt = r_state;
      i_rdy       = 1'b0;
      busy        = 1'b0;
      ap_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ap_start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy  = 1'b1;
            i_rdy = (w_fifo_count < FIFO_CNT_MAX) && (r_beats_acc < r_beats_total);
            if (r_words_cnt == r_words_total) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            ap_done     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Frame configuration latched on start, plus the accepted-beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wpb         <= '0;
         r_beats_total <= '0;
         r_words_total <= '0;
         r_beats_acc   <= '0;
      end else if (w_start) begin
         r_wpb         <= calc_wpb(och);
         r_beats_total <= calc_beats(ofm_w, och);
         r_words_total <= calc_words(ofm_w, och);
         r_beats_acc   <= '0;
      end else if (w_push) begin
         r_beats_acc   <= r_beats_acc + 1'b1;
      end
   end

   // Serializer: one word of the FIFO head per cycle; the head is popped with its last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_en        <= 1'b0;
         w_addr      <= '0;
         w_data      <= '0;
         r_k         <= '0;
         r_words_cnt <= '0;
      end else begin
         w_en <= 1'b0;
         if (w_start) begin
            r_k         <= '0;
            r_words_cnt <= '0;
         end else if (w_issue) begin
            w_en        <= 1'b1;
            w_addr      <= r_words_cnt[ADDR_W-1:0];
            w_data      <= w_head_words[r_k];
            r_words_cnt <= r_words_cnt + 1'b1;
            r_k         <= w_last_k ? 2'd0 : r_k + 1'b1;
         end
      end
   end

endmodule
